// File: rtl/attn_tile_scheduler_pkg.sv
// Shared types and defaults for the FlashAttention tile scheduler and the
// memory controller that consumes its command stream.
package attn_tile_scheduler_pkg;

  localparam int DEF_SEQ_LEN   = 64;
  localparam int DEF_NUM_PES   = 8;
  localparam int DEF_ROW_BYTES = 128;

  localparam int ADDR_W        = 32;
  localparam int CMD_ROW_W_MAX = 16;

  typedef logic [ADDR_W-1:0] ADDR;

  localparam ADDR DEF_Q_BASE = 32'h0000_0000;
  localparam ADDR DEF_K_BASE = 32'h0001_0000;
  localparam ADDR DEF_V_BASE = 32'h0002_0000;
  localparam ADDR DEF_O_BASE = 32'h0003_0000;

  typedef enum logic [1:0] {
    CMD_LOAD_Q  = 2'd0,
    CMD_LOAD_K  = 2'd1,
    CMD_LOAD_V  = 2'd2,
    CMD_STORE_O = 2'd3
  } CMD_TYPE_T;

  // One command as seen by the memory controller; row is sized for the
  // largest supported sequence length.
  typedef struct packed {
    CMD_TYPE_T                  cmd_type;
    ADDR                        addr;
    logic [CMD_ROW_W_MAX-1:0]   row;
  } SCHED_CMD_T;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_Q    = 3'd1,
    ST_STREAM_KV = 3'd2,
    ST_WAIT_O    = 3'd3,
    ST_DRAIN_O   = 3'd4,
    ST_DONE      = 3'd5
  } sched_state_t;

  // True when v is a positive power of two (row stride can then be a shift).
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/attn_tile_scheduler_addr_gen.sv
// Byte address of a matrix row: base of the selected matrix plus
// row * ROW_BYTES, wrapping at 32 bits.
module sched_addr_gen
  import attn_tile_scheduler_pkg::*;
#(
  parameter int  ROW_W     = 6,
  parameter int  ROW_BYTES = DEF_ROW_BYTES,
  parameter ADDR Q_BASE    = DEF_Q_BASE,
  parameter ADDR K_BASE    = DEF_K_BASE,
  parameter ADDR V_BASE    = DEF_V_BASE,
  parameter ADDR O_BASE    = DEF_O_BASE
) (
  input  CMD_TYPE_T        i_type,
  input  logic [ROW_W-1:0] i_row,
  output ADDR              o_addr
);

  ADDR w_base;
  ADDR w_offset;

  // Pick the matrix base for the command type.
  always_comb begin
    w_base = Q_BASE;
    case (i_type)
      CMD_LOAD_Q:  w_base = Q_BASE;
      CMD_LOAD_K:  w_base = K_BASE;
      CMD_LOAD_V:  w_base = V_BASE;
      CMD_STORE_O: w_base = O_BASE;
      default:     w_base = Q_BASE;
    endcase
  end

  generate
    if (is_pow2(ROW_BYTES)) begin : g_shift
      localparam int SH = $clog2(ROW_BYTES);
      assign w_offset = ADDR'(i_row) << SH;
    end else begin : g_mult
      assign w_offset = ADDR'(i_row) * ADDR'(ROW_BYTES);
    end
  endgenerate

  assign o_addr = w_base + w_offset;

endmodule

// File: rtl/attn_tile_scheduler.sv
// FlashAttention pass sequencer: per Q tile issues Q row loads, interleaved
// K/V row loads for the whole sequence, then O row stores, over a registered
// valid/ready command channel.
module attn_tile_scheduler
  import attn_tile_scheduler_pkg::*;
#(
  parameter int  SEQ_LEN   = DEF_SEQ_LEN,
  parameter int  NUM_PES   = DEF_NUM_PES,
  parameter int  ROW_BYTES = DEF_ROW_BYTES,
  parameter ADDR Q_BASE    = DEF_Q_BASE,
  parameter ADDR K_BASE    = DEF_K_BASE,
  parameter ADDR V_BASE    = DEF_V_BASE,
  parameter ADDR O_BASE    = DEF_O_BASE,
  localparam int ROW_W     = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
  localparam int NUM_TILES = SEQ_LEN / NUM_PES,
  localparam int TILE_W    = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              cmd_vld,
  input  logic              cmd_rdy,
  output logic [1:0]        cmd_type,
  output logic [31:0]       cmd_addr,
  output logic [ROW_W-1:0]  cmd_row,
  input  logic              o_bank_vld,
  output logic [TILE_W-1:0] tile_idx,
  output logic              busy,
  output logic              done
);

  sched_state_t     r_state;
  logic [ROW_W-1:0] r_cnt;
  logic             r_kv_sel;
  logic [TILE_W-1:0] r_tile;
  logic             r_o_pend;
  logic             r_cmd_vld;
  CMD_TYPE_T        r_cmd_type;
  ADDR              r_cmd_addr;
  logic [ROW_W-1:0] r_cmd_row;
  logic             r_busy;
  logic             r_done;

  sched_state_t     w_nxt_state;
  logic [ROW_W-1:0] w_nxt_cnt;
  logic             w_nxt_kv;
  logic [TILE_W-1:0] w_nxt_tile;
  logic             w_nxt_vld;
  CMD_TYPE_T        w_nxt_type;
  logic [ROW_W-1:0] w_nxt_row;
  ADDR              w_nxt_addr;
  logic             w_nxt_busy;
  logic             w_nxt_done;
  logic             w_clr_pend;
  logic             w_xfer;
  logic             w_in_pass;
  logic [ROW_W-1:0] w_tile_base;
  logic             w_last_pe;
  logic             w_last_row;
  logic             w_last_tile;

  assign w_xfer      = r_cmd_vld && cmd_rdy;
  assign w_in_pass   = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_tile_base = ROW_W'(r_tile) * ROW_W'(NUM_PES);
  assign w_last_pe   = (r_cnt == ROW_W'(NUM_PES - 1));
  assign w_last_row  = (r_cnt == ROW_W'(SEQ_LEN - 1));
  assign w_last_tile = (r_tile == TILE_W'(NUM_TILES - 1));

  // Next command is prepared in the same cycle the current one transfers,
  // so the output register refills without a bubble across phase changes.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_kv    = r_kv_sel;
    w_nxt_tile  = r_tile;
    w_nxt_vld   = r_cmd_vld;
    w_nxt_type  = r_cmd_type;
    w_nxt_row   = r_cmd_row;
    w_nxt_busy  = r_busy;
    w_nxt_done  = r_done;
    w_clr_pend  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_nxt_state = ST_LOAD_Q;
          w_nxt_cnt   = '0;
          w_nxt_kv    = 1'b0;
          w_nxt_tile  = '0;
          w_nxt_vld   = 1'b1;
          w_nxt_type  = CMD_LOAD_Q;
          w_nxt_row   = '0;
          w_nxt_busy  = 1'b1;
          w_nxt_done  = 1'b0;
        end
      end
      ST_LOAD_Q: begin
        if (w_xfer) begin
          if (w_last_pe) begin
            w_nxt_state = ST_STREAM_KV;
            w_nxt_cnt   = '0;
            w_nxt_kv    = 1'b0;
            w_nxt_type  = CMD_LOAD_K;
            w_nxt_row   = '0;
          end else begin
            w_nxt_cnt = r_cnt + 1'b1;
            w_nxt_row = r_cmd_row + 1'b1;
          end
        end
      end
      ST_STREAM_KV: begin
        if (w_xfer) begin
          if (!r_kv_sel) begin
            w_nxt_kv   = 1'b1;
            w_nxt_type = CMD_LOAD_V;
          end else if (w_last_row) begin
            w_nxt_kv = 1'b0;
            if (r_o_pend) begin
              w_nxt_state = ST_DRAIN_O;
              w_nxt_cnt   = '0;
              w_nxt_type  = CMD_STORE_O;
              w_nxt_row   = w_tile_base;
              w_clr_pend  = 1'b1;
            end else begin
              w_nxt_state = ST_WAIT_O;
              w_nxt_vld   = 1'b0;
            end
          end else begin
            w_nxt_kv   = 1'b0;
            w_nxt_cnt  = r_cnt + 1'b1;
            w_nxt_type = CMD_LOAD_K;
            w_nxt_row  = r_cnt + 1'b1;
          end
        end
      end
      ST_WAIT_O: begin
        if (r_o_pend) begin
          w_nxt_state = ST_DRAIN_O;
          w_nxt_cnt   = '0;
          w_nxt_vld   = 1'b1;
          w_nxt_type  = CMD_STORE_O;
          w_nxt_row   = w_tile_base;
          w_clr_pend  = 1'b1;
        end
      end
      ST_DRAIN_O: begin
        if (w_xfer) begin
          if (w_last_pe) begin
            if (w_last_tile) begin
              w_nxt_state = ST_DONE;
              w_nxt_vld   = 1'b0;
              w_nxt_busy  = 1'b0;
              w_nxt_done  = 1'b1;
            end else begin
              w_nxt_state = ST_LOAD_Q;
              w_nxt_cnt   = '0;
              w_nxt_tile  = r_tile + 1'b1;
              w_nxt_type  = CMD_LOAD_Q;
              w_nxt_row   = r_cmd_row + 1'b1;
            end
          end else begin
            w_nxt_cnt = r_cnt + 1'b1;
            w_nxt_row = r_cmd_row + 1'b1;
          end
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_vld   = 1'b0;
        w_nxt_busy  = 1'b0;
        w_nxt_done  = 1'b0;
      end
    endcase
  end

  sched_addr_gen #(
    .ROW_W     (ROW_W),
    .ROW_BYTES (ROW_BYTES),
    .Q_BASE    (Q_BASE),
    .K_BASE    (K_BASE),
    .V_BASE    (V_BASE),
    .O_BASE    (O_BASE)
  ) u_addr_gen (
    .i_type (w_nxt_type),
    .i_row  (w_nxt_row),
    .o_addr (w_nxt_addr)
  );

  // State, counters and the registered command/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_kv_sel   <= 1'b0;
      r_tile     <= '0;
      r_cmd_vld  <= 1'b0;
      r_cmd_type <= CMD_LOAD_Q;
      r_cmd_addr <= '0;
      r_cmd_row  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      r_kv_sel   <= w_nxt_kv;
      r_tile     <= w_nxt_tile;
      r_cmd_vld  <= w_nxt_vld;
      r_cmd_type <= w_nxt_type;
      r_cmd_addr <= w_nxt_addr;
      r_cmd_row  <= w_nxt_row;
      r_busy     <= w_nxt_busy;
      r_done     <= w_nxt_done;
    end
  end

  // Sticky "drain bank ready" flag; clearing on DRAIN_O entry wins over a
  // pulse in the same cycle, which is an absorbed duplicate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_o_pend <= 1'b0;
    end else if (w_clr_pend) begin
      r_o_pend <= 1'b0;
    end else if (o_bank_vld && w_in_pass) begin
      r_o_pend <= 1'b1;
    end
  end

  assign cmd_vld  = r_cmd_vld;
  assign cmd_type = r_cmd_type;
  assign cmd_addr = r_cmd_addr;
  assign cmd_row  = r_cmd_row;
  assign tile_idx = r_tile;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
